// File: rtl/dal_phy_pkg.sv
// Shared 4B/5B PHY definitions: line symbols, code tables and receiver FSM encoding.
package dal_phy_pkg;

  localparam int unsigned DWIDTH = 8;
  localparam int unsigned SYM_W  = 5;
  localparam int unsigned ST_W   = 3;

  localparam logic [SYM_W-1:0] SYM_J   = 5'b11000;
  localparam logic [SYM_W-1:0] SYM_K   = 5'b10001;
  localparam logic [SYM_W-1:0] SYM_T   = 5'b01101;
  localparam logic [SYM_W-1:0] SYM_PRE = 5'b10101;

  localparam int unsigned ST_HUNT_IDX = 0;
  localparam int unsigned ST_PRE_IDX  = 1;
  localparam int unsigned ST_DATA_IDX = 2;

  typedef enum logic [ST_W-1:0] {
    ST_HUNT = ST_W'(1 << ST_HUNT_IDX),
    ST_PRE  = ST_W'(1 << ST_PRE_IDX),
    ST_DATA = ST_W'(1 << ST_DATA_IDX)
  } rx_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } dec_t;

  function automatic logic [SYM_W-1:0] enc_4b5b(input logic [3:0] n);
    logic [SYM_W-1:0] s;
    case (n)
      4'h0: s = 5'b11110;  4'h1: s = 5'b01001;
      4'h2: s = 5'b10100;  4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;  4'h5: s = 5'b01011;
      4'h6: s = 5'b01110;  4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;  4'h9: s = 5'b10011;
      4'hA: s = 5'b10110;  4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;  4'hD: s = 5'b11011;
      4'hE: s = 5'b11100;  default: s = 5'b11101;
    endcase
    return s;
  endfunction

  // Reverse lookup; control and unused codes come back with valid cleared.
  function automatic dec_t dec_5b4b(input logic [SYM_W-1:0] s);
    dec_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (enc_4b5b(4'(i)) == s) r = '{valid: 1'b1, nibble: 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_4b5b_deframer_if.sv
// System-side byte/frame status bus produced by the 4B/5B deframer.
interface rx_4b5b_deframer_if;
  import dal_phy_pkg::*;

  logic [DWIDTH-1:0] data_out;
  logic              RX_RDY;
  logic              rx_frame;
  logic              frame_end;
  logic              code_err;

  modport master (output data_out, RX_RDY, rx_frame, frame_end, code_err);
  modport slave  (input  data_out, RX_RDY, rx_frame, frame_end, code_err);
endinterface

// File: rtl/rx_bit_recover.sv
// Line front end: synchroniser, edge-locked sample point, NRZI decode and idle timer.
module rx_bit_recover #(
  parameter int unsigned OVS       = 4,
  parameter int unsigned IDLE_BITS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic bit_c,
  output logic bit_stb_c,
  output logic idle_to_c
);
  localparam int unsigned PHASE_W  = $clog2(OVS);
  localparam int unsigned IDLE_LIM = IDLE_BITS * OVS;
  localparam int unsigned IDLE_W   = $clog2(IDLE_LIM + 1);

  logic               meta_q, s_q, s_prev_q, s_stb_q;
  logic [PHASE_W-1:0] phase_q, phase_c;
  logic [IDLE_W-1:0]  idle_q;
  logic               line_edge_c;

  assign line_edge_c = s_q ^ s_prev_q;
  // The edge cycle itself counts as phase 0, so the sample lands OVS/2 clocks later.
  assign phase_c     = line_edge_c ? '0 : phase_q;
  assign bit_stb_c   = !line_edge_c && (phase_q == PHASE_W'(OVS / 2));
  assign bit_c       = s_q ^ s_stb_q;
  assign idle_to_c   = (idle_q == IDLE_W'(IDLE_LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
      s_stb_q  <= 1'b1;
      phase_q  <= '0;
      idle_q   <= '0;
    end else begin
      meta_q   <= rx;
      s_q      <= meta_q;
      s_prev_q <= s_q;
      if (bit_stb_c) s_stb_q <= s_q;
      phase_q  <= (phase_c == PHASE_W'(OVS - 1)) ? '0 : phase_c + PHASE_W'(1);
      if (line_edge_c)                      idle_q <= '0;
      else if (idle_q != IDLE_W'(IDLE_LIM)) idle_q <= idle_q + IDLE_W'(1);
    end
  end
endmodule

// File: rtl/rx_4b5b_deframer.sv
// 4B/5B NRZI receiver: preamble/JK hunt, symbol-pair to byte decode, T/T end and error reporting.
module rx_4b5b_deframer
  import dal_phy_pkg::*;
#(
  parameter int unsigned OVS       = 4,
  parameter int unsigned IDLE_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX,
  rx_4b5b_deframer_if.master    sys
);
  logic              bit_c, bit_stb_c, idle_to_c;
  rx_state_e         state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        sym_bits_q, sym_bits_d;
  logic [9:0]        sh_q, sh_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              rdy_q, rdy_d, frame_q, frame_d, end_q, end_d, err_q, err_d;
  dec_t              dec_hi_c, dec_lo_c;

  rx_bit_recover #(.OVS(OVS), .IDLE_BITS(IDLE_BITS)) u_bit_recover (
    .clk       (clk),
    .reset     (reset),
    .rx        (RX),
    .bit_c     (bit_c),
    .bit_stb_c (bit_stb_c),
    .idle_to_c (idle_to_c)
  );

  // Decisions are made on the post-shift window so outputs land one clock after the strobe.
  assign sh_d     = bit_stb_c ? {sh_q[8:0], bit_c} : sh_q;
  assign dec_hi_c = dec_5b4b(sh_d[9:5]);
  assign dec_lo_c = dec_5b4b(sh_d[4:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= '0;
      sym_bits_q <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      frame_q    <= 1'b0;
      end_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_bits_q <= sym_bits_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
      frame_q    <= frame_d;
      end_q      <= end_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sym_bits_d = sym_bits_q;
    data_d     = data_q;
    frame_d    = frame_q;
    rdy_d      = 1'b0;
    end_d      = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (bit_stb_c && sh_d[4:0] == SYM_PRE) begin
          state_d   = ST_PRE;
          bit_cnt_d = '0;
        end
      end
      ST_PRE: begin
        if (idle_to_c) begin
          state_d = ST_HUNT;
        end else if (bit_stb_c) begin
          if (sh_d == {SYM_J, SYM_K}) begin
            state_d    = ST_DATA;
            frame_d    = 1'b1;
            sym_bits_d = '0;
          end else if (sh_d[4:0] == SYM_PRE) begin
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_d == 5'd31) state_d = ST_HUNT;
          end
        end
      end
      ST_DATA: begin
        if (idle_to_c) begin
          err_d   = 1'b1;
          frame_d = 1'b0;
          state_d = ST_HUNT;
        end else if (bit_stb_c) begin
          if (sym_bits_q == 4'd9) begin
            sym_bits_d = '0;
            if (dec_hi_c.valid && dec_lo_c.valid) begin
              data_d = {dec_hi_c.nibble, dec_lo_c.nibble};
              rdy_d  = 1'b1;
            end else if (sh_d == {SYM_T, SYM_T}) begin
              end_d   = 1'b1;
              frame_d = 1'b0;
              state_d = ST_HUNT;
            end else begin
              err_d   = 1'b1;
              frame_d = 1'b0;
              state_d = ST_HUNT;
            end
          end else begin
            sym_bits_d = sym_bits_q + 4'd1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  assign sys.data_out  = data_q;
  assign sys.RX_RDY    = rdy_q;
  assign sys.rx_frame  = frame_q;
  assign sys.frame_end = end_q;
  assign sys.code_err  = err_q;
endmodule

// File: tb/tb_rx_4b5b_deframer.sv
// Bench for rx_4b5b_deframer: vector table of frames plus reset, timeout and mid-frame sequences.
module tb_rx_4b5b_deframer;
  localparam int unsigned OVS       = 4;
  localparam int unsigned IDLE_BITS = 5;
  localparam logic [4:0] S_J = 5'b11000, S_K = 5'b10001, S_T = 5'b01101, S_P = 5'b10101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic RX = 1'b1;

  rx_4b5b_deframer_if sys();

  rx_4b5b_deframer #(.OVS(OVS), .IDLE_BITS(IDLE_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .RX    (RX),
    .sys   (sys)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       pre;
    int         nbytes;
    logic [7:0] b0, b1, b2;
    logic       bad;
    int         lo, hi;
    int         exp_rdy, exp_fe, exp_ce;
  } vec_t;

  vec_t       vecs[$];
  int         n_vec = 0, n_err = 0;
  int         rdy_cnt = 0, fe_cnt = 0, ce_cnt = 0, rise_cnt = 0;
  int         cyc = 0, fe_t = 0;
  int         rdy_t[$];
  logic [7:0] exp_q[$];
  logic       line_lvl = 1'b1;
  logic       jsel = 1'b0;
  logic       frame_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard/monitor on the system-side bus.
  always @(negedge clk) begin
    if (reset) begin
      frame_prev <= 1'b0;
    end else begin
      int np;
      np = int'(sys.RX_RDY) + int'(sys.frame_end) + int'(sys.code_err);
      if (np != 0) check("pulse_exclusive", np, 1);
      if (sys.rx_frame && !frame_prev) rise_cnt++;
      frame_prev <= sys.rx_frame;
      if (sys.RX_RDY) begin
        rdy_cnt++;
        rdy_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rdy_unexpected: got data 0x%0h, expected no strobe", sys.data_out);
        end else begin
          check("data_out", sys.data_out, exp_q.pop_front());
        end
        check("frame_at_rdy", sys.rx_frame, 1);
      end
      if (sys.frame_end) begin
        fe_cnt++;
        fe_t = cyc;
        check("frame_fall_on_end", sys.rx_frame, 0);
      end
      if (sys.code_err) begin
        ce_cnt++;
        check("frame_fall_on_err", sys.rx_frame, 0);
      end
    end
  end

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;  4'h1: return 5'b01001;  4'h2: return 5'b10100;  4'h3: return 5'b10101;
      4'h4: return 5'b01010;  4'h5: return 5'b01011;  4'h6: return 5'b01110;  4'h7: return 5'b01111;
      4'h8: return 5'b10010;  4'h9: return 5'b10011;  4'hA: return 5'b10110;  4'hB: return 5'b10111;
      4'hC: return 5'b11010;  4'hD: return 5'b11011;  4'hE: return 5'b11100;  default: return 5'b11101;
    endcase
  endfunction

  task automatic tx_bit(input logic b, input int lo, input int hi);
    int per;
    if (b) line_lvl = ~line_lvl;
    RX  = line_lvl;
    per = jsel ? hi : lo;
    jsel = ~jsel;
    repeat (per) @(negedge clk);
  endtask

  task automatic tx_sym(input logic [4:0] s, input int lo, input int hi);
    for (int i = 4; i >= 0; i--) tx_bit(s[i], lo, hi);
  endtask

  task automatic tx_idle(input int n);
    RX = line_lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic add_vec(input string name, input logic pre, input int nb,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic bad, input int lo, input int hi,
                         input int er, input int efe, input int ece);
    vec_t v;
    v.name = name; v.pre = pre; v.nbytes = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.bad = bad; v.lo = lo; v.hi = hi; v.exp_rdy = er; v.exp_fe = efe; v.exp_ce = ece;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] bytes[3];
    int r0, f0, c0, s0;
    bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
    r0 = rdy_cnt; f0 = fe_cnt; c0 = ce_cnt; s0 = rise_cnt;
    rdy_t.delete();
    jsel = 1'b0;
    if (v.pre) repeat (4) tx_sym(S_P, v.lo, v.hi);
    tx_sym(S_J, v.lo, v.hi);
    tx_sym(S_K, v.lo, v.hi);
    for (int i = 0; i < v.nbytes; i++) begin
      if (v.exp_rdy > i) exp_q.push_back(bytes[i]);
      tx_sym(enc(bytes[i][7:4]), v.lo, v.hi);
      tx_sym(enc(bytes[i][3:0]), v.lo, v.hi);
    end
    if (v.bad) begin
      tx_sym(5'b00000, v.lo, v.hi);
      tx_sym(5'b11110, v.lo, v.hi);
    end
    tx_sym(S_T, v.lo, v.hi);
    tx_sym(S_T, v.lo, v.hi);
    tx_idle(80);
    check({v.name, "_rdy_count"},   rdy_cnt - r0, v.exp_rdy);
    check({v.name, "_end_count"},   fe_cnt - f0, v.exp_fe);
    check({v.name, "_err_count"},   ce_cnt - c0, v.exp_ce);
    check({v.name, "_frame_rises"}, rise_cnt - s0, v.pre ? 1 : 0);
    check({v.name, "_frame_idle"},  sys.rx_frame, 0);
    if (v.lo == 4 && v.hi == 4 && v.exp_rdy > 0) begin
      for (int i = 1; i < rdy_t.size(); i++)
        check({v.name, "_rdy_spacing"}, rdy_t[i] - rdy_t[i-1], 10 * OVS);
      if (v.exp_fe == 1 && rdy_t.size() > 0)
        check({v.name, "_end_after_rdy"}, fe_t - rdy_t[rdy_t.size()-1], 10 * OVS);
    end
  endtask

  initial begin
    int r0, f0, c0;
    add_vec("single",  1'b1, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 4, 4, 1, 1, 0);
    add_vec("b2b",     1'b1, 3, 8'h00, 8'hFF, 8'h3C, 1'b0, 4, 4, 3, 1, 0);
    add_vec("badcode", 1'b1, 1, 8'h12, 8'h00, 8'h00, 1'b1, 4, 4, 1, 0, 1);
    add_vec("jitter",  1'b1, 1, 8'h5A, 8'h00, 8'h00, 1'b0, 3, 5, 1, 1, 0);
    add_vec("nopre",   1'b0, 1, 8'h77, 8'h00, 8'h00, 1'b0, 4, 4, 0, 0, 0);

    // Reset held with the line toggling.
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      RX = ~RX;
    end
    @(negedge clk);
    check("rst_data_out",  sys.data_out, 0);
    check("rst_rdy",       sys.RX_RDY, 0);
    check("rst_frame",     sys.rx_frame, 0);
    check("rst_frame_end", sys.frame_end, 0);
    check("rst_code_err",  sys.code_err, 0);
    line_lvl = 1'b1;
    RX = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_pulses", rdy_cnt + fe_cnt + ce_cnt, 0);
    check("idle_frame",  sys.rx_frame, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Line freezes at a byte boundary inside a frame.
    r0 = rdy_cnt; f0 = fe_cnt; c0 = ce_cnt;
    jsel = 1'b0;
    repeat (4) tx_sym(S_P, 4, 4);
    tx_sym(S_J, 4, 4);
    tx_sym(S_K, 4, 4);
    exp_q.push_back(8'h11);
    tx_sym(enc(4'h1), 4, 4);
    tx_sym(enc(4'h1), 4, 4);
    check("to_frame_before", sys.rx_frame, 1);
    tx_idle(40);
    check("to_err_count", ce_cnt - c0, 1);
    check("to_rdy_count", rdy_cnt - r0, 1);
    check("to_end_count", fe_cnt - f0, 0);
    check("to_frame_after", sys.rx_frame, 0);
    tx_idle(40);

    // Reset lands in the middle of a byte.
    r0 = rdy_cnt; f0 = fe_cnt; c0 = ce_cnt;
    jsel = 1'b0;
    repeat (4) tx_sym(S_P, 4, 4);
    tx_sym(S_J, 4, 4);
    tx_sym(S_K, 4, 4);
    tx_sym(enc(4'h6), 4, 4);
    tx_bit(1'b1, 4, 4);
    tx_bit(1'b1, 4, 4);
    check("mr_frame_before", sys.rx_frame, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mr_data_out", sys.data_out, 0);
    check("mr_frame",    sys.rx_frame, 0);
    check("mr_rdy",      sys.RX_RDY, 0);
    reset = 1'b0;
    tx_bit(1'b1, 4, 4);
    tx_bit(1'b0, 4, 4);
    tx_bit(1'b1, 4, 4);
    tx_sym(S_T, 4, 4);
    tx_sym(S_T, 4, 4);
    tx_idle(80);
    check("mr_rdy_count", rdy_cnt - r0, 0);
    check("mr_end_count", fe_cnt - f0, 0);
    check("mr_err_count", ce_cnt - c0, 0);
    check("mr_frame_after", sys.rx_frame, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
